mic_sample_arbiter: RTL
=======================

MIC_SAMPLE_ARBITER -- requirements
Module: mic_sample_arbiter

Interface
REQ-001 Parameter NUM_CH, default 4: number of microphone sample channels, legal range 2..8.
REQ-002 Parameter DW, default 18: sample width in bits, two's complement.
REQ-003 clock  input  1  system clock; all state changes on its rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 ch_data  input  NUM_CH*DW  per-channel sample; channel i occupies bits [i*DW +: DW].
REQ-006 ch_rdy  input  NUM_CH  per-channel one-cycle strobe; bit i means ch_data for channel i is valid this cycle.
REQ-007 out_data  output  DW  granted sample, unmodified.
REQ-008 out_ch  output  clog2(NUM_CH)  index of the channel that produced out_data.
REQ-009 out_valid  output  1  out_data and out_ch are valid.
REQ-010 out_ready  input  1  downstream accepts; a transfer occurs on a cycle where out_valid and out_ready are both 1.
REQ-011 overflow  output  NUM_CH  sticky per-channel dropped-sample flag.
REQ-012 clear_ovf  input  NUM_CH  per-channel clear strobe for overflow.

Function
REQ-013 Each channel SHALL hold a one-entry buffer (sample and pending bit).
REQ-014 ch_rdy[i]=1 with pending[i]=0 SHALL capture ch_data[i] and set pending[i] at the same edge.
REQ-015 ch_rdy[i]=1 with pending[i]=1 and buffer i not unloaded this cycle SHALL drop the new sample, keep the old sample, and set overflow[i].
REQ-016 ch_rdy[i]=1 on the cycle buffer i is unloaded into the output register SHALL capture the new sample with no overflow.
REQ-017 The output register SHALL load when out_valid=0, or when out_valid=1 and out_ready=1, and at least one pending bit is set.
REQ-018 The channel loaded SHALL be the first pending channel in round-robin order, starting at last_grant+1 and wrapping modulo NUM_CH.
REQ-019 Loading SHALL clear pending for the granted channel, update last_grant, and set out_valid.
REQ-020 A transfer with no pending channel SHALL clear out_valid at that edge.
REQ-021 While out_valid=1 and out_ready=0, out_data and out_ch SHALL hold stable.
REQ-022 Minimum latency from a ch_rdy edge to out_valid SHALL be one cycle: capture at edge k, out_valid=1 after edge k+1.
REQ-023 With out_ready held at 1 and requests continuously pending, the block SHALL sustain one transfer per cycle.
REQ-024 A sample SHALL NOT bypass its buffer: same-cycle ch_rdy does not appear on out_data at that edge.
REQ-025 clear_ovf[i] SHALL clear overflow[i] at the next edge.
REQ-026 If an overflow event and clear_ovf[i] occur in the same cycle, overflow[i] SHALL be set (set wins).
REQ-027 Any number of ch_rdy bits SHALL be accepted in the same cycle, each handled independently per REQ-014..016.

Reset
REQ-028 reset SHALL clear all pending bits, all buffer samples, out_valid, out_data, out_ch and overflow to 0.
REQ-029 reset SHALL set last_grant to NUM_CH-1, so channel 0 has first priority.
REQ-030 reset asserted mid-transfer SHALL discard buffered and held samples with no transfer reported.
REQ-031 ch_rdy and out_ready SHALL be ignored while reset=1.

Verification
REQ-032 After reset, pulse ch_rdy=4'b0100 with ch_data[2]=18'h1FFFF and out_ready=1 -> one cycle later out_valid=1, out_ch=2, out_data=18'h1FFFF; out_valid=0 on the following cycle.
REQ-033 After reset, with out_ready=0, pulse ch_rdy=4'b1111 with samples 1,2,3,4, then raise out_ready -> transfers in channel order 0,1,2,3, with data 1,2,3,4, one per cycle.
REQ-034 With out_ready=0, pulse ch_rdy[1] three times with data 5, 6, 7 -> out_data=5 held; buffer 1 holds 6; overflow=4'b0010; after draining, data 7 never appears.
REQ-035 With out_ready=0, ch_rdy[3] and clear_ovf[3] in the same cycle while pending[3]=1 -> overflow[3]=1; clear_ovf[3] alone on the next cycle -> overflow[3]=0.
REQ-036 Hold channels 0 and 1 continuously pending (ch_rdy re-strobed on each unload) with out_ready=1 -> out_ch alternates 0,1,0,1 with no gaps and no overflow.
REQ-037 Assert reset while out_valid=1 and out_ready=0 with two channels pending -> all outputs 0 next cycle; the first post-reset request grants channel 0 priority.

Source files
------------

// File: rtl/mic_sample_arbiter.sv
// rtl/mic_sample_arbiter.sv - round-robin arbiter merging per-channel mic samples into one stream
//
// Purpose:
//   Each microphone channel owns a one-entry buffer (sample + pending bit).
//   A single output register is refilled from the first pending buffer in
//   round-robin order whenever it is empty or being drained. New strobes on
//   a full, non-draining buffer are dropped and flagged in a sticky overflow bit.
//
// Ports:
//   clock      in   system clock, rising edge
//   reset      in   synchronous, active-high
//   ch_data    in   NUM_CH*DW  per-channel sample, channel i at [i*DW +: DW]
//   ch_rdy     in   NUM_CH     per-channel sample strobe
//   out_data   out  DW         granted sample
//   out_ch     out  clog2      channel index of out_data
//   out_valid  out  1          out_data/out_ch valid
//   out_ready  in   1          downstream accept
//   overflow   out  NUM_CH     sticky dropped-sample flags
//   clear_ovf  in   NUM_CH     per-channel overflow clear strobe

module mic_sample_arbiter #(
  parameter int NUM_CH = 4,
  parameter int DW     = 18
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_CH*DW-1:0]       ch_data,
  input  logic [NUM_CH-1:0]          ch_rdy,
  output logic [DW-1:0]              out_data,
  output logic [$clog2(NUM_CH)-1:0]  out_ch,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NUM_CH-1:0]          overflow,
  input  logic [NUM_CH-1:0]          clear_ovf
);

  localparam int CW = $clog2(NUM_CH);

  logic [NUM_CH-1:0][DW-1:0] r_buf;
  logic [NUM_CH-1:0]         r_pending;
  logic [NUM_CH-1:0]         r_ovf;
  logic [CW-1:0]             r_last_grant;
  logic [DW-1:0]             r_out_data;
  logic [CW-1:0]             r_out_ch;
  logic                      r_out_valid;

  logic [CW-1:0]             w_grant;
  logic                      w_load;
  logic [NUM_CH-1:0]         w_unload;

  // Scan from the farthest offset down to the nearest so the first pending
  // channel after last_grant is the one left in w_grant.
  always_comb begin
    w_grant = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      if (r_pending[(int'(r_last_grant) + k) % NUM_CH]) begin
        w_grant = CW'((int'(r_last_grant) + k) % NUM_CH);
      end
    end
  end

  assign w_load = (!r_out_valid || out_ready) && (|r_pending);

  always_comb begin
    w_unload = '0;
    if (w_load) begin
      w_unload[w_grant] = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_buf        <= '0;
      r_pending    <= '0;
      r_ovf        <= '0;
      r_last_grant <= CW'(NUM_CH - 1);
      r_out_data   <= '0;
      r_out_ch     <= '0;
      r_out_valid  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        // A buffer being unloaded this edge is free again, so a coincident
        // strobe refills it instead of overflowing.
        if (w_unload[i]) begin
          r_pending[i] <= ch_rdy[i];
          if (ch_rdy[i]) begin
            r_buf[i] <= ch_data[i*DW +: DW];
          end
        end else if (ch_rdy[i] && !r_pending[i]) begin
          r_pending[i] <= 1'b1;
          r_buf[i]     <= ch_data[i*DW +: DW];
        end

        // Set has priority over clear.
        if (ch_rdy[i] && r_pending[i] && !w_unload[i]) begin
          r_ovf[i] <= 1'b1;
        end else if (clear_ovf[i]) begin
          r_ovf[i] <= 1'b0;
        end
      end

      if (w_load) begin
        r_out_data   <= r_buf[w_grant];
        r_out_ch     <= w_grant;
        r_out_valid  <= 1'b1;
        r_last_grant <= w_grant;
      end else if (r_out_valid && out_ready) begin
        r_out_valid  <= 1'b0;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;
  assign out_valid = r_out_valid;
  assign overflow  = r_ovf;

endmodule
